// File: rtl/softmax_seq_ctrl.sv
// Issue/credit sequencer for a fixed-latency softmax core: in->out LATENCY cycles, FWFT result FIFO.
// Backpressure: input credit is withheld while in-flight plus buffered vectors would exceed the FIFO.
module softmax_seq_ctrl #(
  parameter int N          = 10,
  parameter int WIDTH      = 16,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [N-1:0][WIDTH-1:0] in_data,
  output logic signed [N-1:0][WIDTH-1:0] core_dataIn,
  input  logic signed [N-1:0][WIDTH-1:0] core_dataOut,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [N-1:0][WIDTH-1:0] out_data,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           frame_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [LATENCY-1:0]     shift;
  logic [N-1:0][WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          fifo_count;
  logic [SW-1:0]          inflight;
  logic                   credit_ok;
  logic                   accept;
  logic                   fifo_wr;
  logic                   fifo_rd;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + SW'(shift[i]);
  end

  // Conservative credit: a pop in the same cycle does not free a slot.
  assign credit_ok = (inflight + SW'(fifo_count)) < SW'(FIFO_DEPTH);
  assign in_ready  = (state == RUN) && credit_ok && !flush;
  assign accept    = in_valid && in_ready;
  assign fifo_wr   = shift[LATENCY-1];
  assign out_valid = (fifo_count != '0);
  assign fifo_rd   = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE) || out_valid;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      shift       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      core_dataIn <= '0;
      frame_count <= '0;
    end else if (flush) begin
      state      <= IDLE;
      shift      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      shift <= (shift << 1) | LATENCY'(accept);
      if (accept) core_dataIn <= in_data;
      if (fifo_wr) wr_ptr <= nxt(wr_ptr);
      if (fifo_rd) begin
        rd_ptr      <= nxt(rd_ptr);
        frame_count <= frame_count + CNT_WIDTH'(1);
      end
      fifo_count <= fifo_count + CW'(fifo_wr) - CW'(fifo_rd);
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN:   if (enable) state <= RUN;
                 else if (inflight == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && fifo_wr) mem[wr_ptr] <= core_dataOut;
  end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl: transaction-level model plus a fixed-latency stand-in for the softmax core.
module tb_softmax_seq_ctrl;

  localparam int N   = 10;
  localparam int W   = 16;
  localparam int LAT = 3;
  localparam int DEP = 5;
  localparam int CNW = 4;
  localparam int VW  = N * W;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct { vec_t d; int due; } fl_t;

  logic clk, reset, enable, flush, in_valid, out_ready;
  logic in_ready, out_valid, busy;
  vec_t in_data, core_dataIn, out_data, cp0, cp1;
  logic [CNW-1:0] frame_count;

  softmax_seq_ctrl #(.N(N), .WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(DEP), .CNT_WIDTH(CNW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_dataIn(core_dataIn), .core_dataOut(cp1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t f(input vec_t v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v[i] ^ 16'hA5A5;
    return r;
  endfunction

  function automatic vec_t mk(input int k);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = W'(k * 256 + i * 7);
    return r;
  endfunction

  // Core stand-in: result of a core_dataIn update at edge t is present for capture at edge t+LAT.
  always @(posedge clk) begin
    cp0 <= f(core_dataIn);
    cp1 <= cp0;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Transaction-level model
  int   m_state = 0;
  fl_t  flq[$];
  vec_t fq[$];
  vec_t m_cdi = '0;
  int   m_fc = 0;
  int   ecnt = 0;
  int   n_acc = 0;
  int   next_k = 0;
  bit   started = 0;

  function automatic bit exp_rdy();
    return (m_state == 1) && ((flq.size() + fq.size()) < DEP) && !flush;
  endfunction

  task automatic model_step();
    fl_t tmp;
    int  infl;
    bit  acc;
    if (!reset) begin
      m_state = 0; flq.delete(); fq.delete(); m_cdi = '0; m_fc = 0; started = 1;
    end else if (flush) begin
      m_state = 0; flq.delete(); fq.delete();
    end else begin
      acc  = in_valid && exp_rdy();
      infl = flq.size();
      if (fq.size() != 0 && out_ready) begin
        void'(fq.pop_front());
        m_fc = (m_fc + 1) % (1 << CNW);
      end
      if (flq.size() != 0 && flq[0].due == ecnt) begin
        tmp = flq.pop_front();
        fq.push_back(tmp.d);
      end
      if (acc) begin
        tmp.d = f(in_data); tmp.due = ecnt + LAT;
        flq.push_back(tmp);
        m_cdi = in_data; n_acc++; next_k++;
      end
      case (m_state)
        0: if (enable) m_state = 1;
        1: if (!enable) m_state = 2;
        default: if (enable) m_state = 1; else if (infl == 0) m_state = 0;
      endcase
    end
    ecnt++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (started) begin
        chk("in_ready", in_ready, exp_rdy());
        chk("out_valid", out_valid, fq.size() != 0);
        chk("busy", busy, (m_state != 0) || (fq.size() != 0));
        chk("frame_count", frame_count, m_fc);
        chk("core_dataIn", core_dataIn, m_cdi);
        if (fq.size() != 0) chk("out_data", out_data, fq[0]);
      end
      model_step();
    end
  end

  task automatic send(input int n, input int budget);
    int start, c;
    start = n_acc; c = 0;
    in_valid = 1'b1; in_data = mk(next_k);
    while (n_acc < start + n && c < budget) begin
      @(negedge clk); c++; in_data = mk(next_k);
    end
    in_valid = 1'b0;
    chk("send_count", n_acc - start, n);
  endtask

  initial begin
    int base;
    reset = 1'b0; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);

    // Single vector: accept at edge 2, result visible from edge 5
    reset = 1'b1; enable = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = mk(next_k);
    @(negedge clk); in_valid = 1'b0; #2;
    chk("t1_cdi_lane9", core_dataIn[9], 16'd63);
    @(negedge clk);
    @(negedge clk); #2;
    chk("t1_ov_edge4", out_valid, 1'b0);
    @(negedge clk); #2;
    chk("t1_ov_edge5", out_valid, 1'b1);
    chk("t1_data_lane0", out_data[0], 16'hA5A5);
    chk("t1_data_lane9", out_data[9], 16'hA59A);
    out_ready = 1'b1;
    @(negedge clk); #2;
    chk("t1_fc", frame_count, 4'd1);
    chk("t1_ov_after", out_valid, 1'b0);

    // 20 back-to-back vectors
    send(20, 60);
    repeat (6) @(negedge clk); #2;
    chk("t2_fc_wrapped", frame_count, 4'd5);

    // Consumer stalled: only FIFO_DEPTH accepted
    out_ready = 1'b0; base = n_acc; in_valid = 1'b1;
    repeat (12) begin in_data = mk(next_k); @(negedge clk); end
    #2;
    chk("t3_accepted", n_acc - base, DEP);
    chk("t3_in_ready_low", in_ready, 1'b0);
    chk("t3_ov", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(negedge clk); #2;
    chk("t3_in_ready_back", in_ready, 1'b1);
    chk("t3_drained", out_valid, 1'b0);
    chk("t3_fc", frame_count, 4'd10);

    // enable drops with three vectors in flight
    out_ready = 1'b0; base = n_acc;
    send(3, 10);
    enable = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = mk(next_k); #2;
    chk("t4_in_ready", in_ready, 1'b0);
    chk("t4_busy", busy, 1'b1);
    repeat (4) @(negedge clk); #2;
    chk("t4_accepted", n_acc - base, 3);
    chk("t4_ov", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk); #2;
    chk("t4_idle", busy, 1'b0);
    chk("t4_fc", frame_count, 4'd13);

    // flush with two in flight and two buffered
    enable = 1'b1; out_ready = 1'b0;
    send(4, 10);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = mk(next_k); base = n_acc; #2;
    chk("t5_in_ready", in_ready, 1'b0);
    chk("t5_ov_before", out_valid, 1'b1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #2;
    chk("t5_ov_cleared", out_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    repeat (6) @(negedge clk); #2;
    chk("t5_no_stale", out_valid, 1'b0);
    chk("t5_no_accept", n_acc - base, 0);
    chk("t5_fc_kept", frame_count, 4'd13);

    // reset mid-stream, then counter wrap
    send(3, 10);
    reset = 1'b0; in_valid = 1'b1;
    @(negedge clk); #2;
    chk("t6_in_ready", in_ready, 1'b0);
    chk("t6_ov", out_valid, 1'b0);
    chk("t6_out_data", out_data, '0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_fc", frame_count, 4'd0);
    chk("t6_cdi", core_dataIn, '0);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    send(16, 50);
    repeat (6) @(negedge clk); #2;
    chk("t6_wrap16", frame_count, 4'd0);
    send(1, 10);
    repeat (5) @(negedge clk); #2;
    chk("t6_wrap17", frame_count, 4'd1);

    enable = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
